pair_scan_ctrl: RTL and testbench

//  Sequencer for the serial two-consecutive-ones detector. Accepts a

---
 rtl/pair_scan_ctrl_pkg.sv | 23 ++
 rtl/pair_scan_ctrl_if.sv | 14 +
 rtl/pair_scan_ctrl_run2_detect.sv | 30 +++
 rtl/pair_scan_ctrl.sv | 78 +++++++
 tb/tb_pair_scan_ctrl.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/pair_scan_ctrl_pkg.sv
// Shared types and sizing helper for the pair-scan sequencer and its
// serial run detector.
package pair_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } ctrl_state_e;

  typedef enum logic [1:0] {
    DET_A = 2'b00,
    DET_B = 2'b01,
    DET_C = 2'b10
  } det_state_e;

  // Hit counter width; a word of WIDTH bits holds at most WIDTH-1 pairs.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/pair_scan_ctrl_if.sv
// Producer-side bus of the pair-scan sequencer: start strobe, word, status
// and result.
interface pair_scan_ctrl_if #(parameter int WIDTH = 8);
  localparam int CNT_W = pair_scan_pkg::cnt_w(WIDTH);

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] hits;

  modport master (output start, data_in, input busy, done, hits);
  modport slave  (input start, data_in, output busy, done, hits);
endinterface

// File: rtl/pair_scan_ctrl_run2_detect.sv
// Registered Moore detector: z is high once the two most recent serial bits
// were both 1. clr restarts the search.
module run2_detect
  import pair_scan_pkg::*;
(
  input  logic clk,
  input  logic Resetn,
  input  logic clr,
  input  logic w,
  output logic z
);

  det_state_e st_q;

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn)   st_q <= DET_A;
    else if (clr)  st_q <= DET_A;
    else if (!w)   st_q <= DET_A;
    else begin
      case (st_q)
        DET_A:        st_q <= DET_B;
        DET_B, DET_C: st_q <= DET_C;
        default:      st_q <= DET_A;  // stray 2'b11 recovers
      endcase
    end
  end

  assign z = (st_q == DET_C);

endmodule

// File: rtl/pair_scan_ctrl.sv
// Sequencer: captures a word on start, shifts it LSB-first through the run
// detector, counts adjacent-ones pairs and reports them with a done pulse.
module pair_scan_ctrl
  import pair_scan_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           Resetn,
  pair_scan_ctrl_if.slave bus
);

  localparam int CNT_W = cnt_w(WIDTH);

  ctrl_state_e      state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] bcnt_q;
  logic [CNT_W-1:0] hits_q;
  logic             busy_q;
  logic             done_q;

  logic clr, w, z;

  assign clr = (state_q == IDLE) && bus.start;
  assign w   = (state_q == SHIFT) && shreg_q[0];

  run2_detect u_det (
    .clk    (clk),
    .Resetn (Resetn),
    .clr    (clr),
    .w      (w),
    .z      (z)
  );

  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      hits_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // z lags w by one edge, so DRAIN is needed to see the final bit pair
      if (((state_q == SHIFT) || (state_q == DRAIN)) && z)
        hits_q <= hits_q + 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            shreg_q <= bus.data_in;
            hits_q  <= '0;
            bcnt_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          shreg_q <= shreg_q >> 1;
          bcnt_q  <= bcnt_q + 1'b1;
          if (bcnt_q == CNT_W'(WIDTH - 1)) state_q <= DRAIN;
        end
        DRAIN: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= DONE;
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hits = hits_q;

endmodule

// File: tb/tb_pair_scan_ctrl.sv
// Bench for pair_scan_ctrl at WIDTH=8: vector table of words with expected
// pair counts, plus hand-written held-start and mid-scan reset sequences.
module tb_pair_scan_ctrl;
  localparam int WIDTH = 8;
  localparam int NVEC  = 14;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               exp_hits;
    string            name;
  } vec_t;

  logic clk    = 1'b0;
  logic Resetn = 1'b0;

  pair_scan_ctrl_if #(.WIDTH(WIDTH)) bus ();
  pair_scan_ctrl #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];
  vec_t vecs[NVEC];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int pairs(input logic [WIDTH-1:0] d);
    int n = 0;
    for (int i = 1; i < WIDTH; i++) if (d[i] && d[i-1]) n++;
    return n;
  endfunction

  // One scan: start accepted at E0, busy for 9 samples, done at the 10th.
  task automatic run_scan(input logic [WIDTH-1:0] d, input int exp, input string name);
    int busy_n = 0;
    int done_n = 0;
    int done_k = -1;
    exp_q.delete();
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = d;
    exp_q.push_back(exp);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.start = 1'b0;
        check($sformatf("%s hits cleared", name), int'(bus.hits), 0);
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        done_k = k;
        if (exp_q.size() > 0) check($sformatf("%s hits", name), int'(bus.hits), exp_q.pop_front());
        else check($sformatf("%s unexpected done", name), 1, 0);
      end
    end
    check($sformatf("%s busy cycles", name), busy_n, 9);
    check($sformatf("%s done count", name), done_n, 1);
    check($sformatf("%s done cycle", name), done_k, 9);
    check($sformatf("%s hits held", name), int'(bus.hits), exp);
  endtask

  initial begin
    int dk[$];
    int done_n;

    vecs[0]  = '{8'hFF,        7, "ff"};
    vecs[1]  = '{8'b0110_1110, 3, "6e"};
    vecs[2]  = '{8'h55,        0, "55"};
    vecs[3]  = '{8'h00,        0, "00"};
    vecs[4]  = '{8'hC0,        1, "c0 msb pair"};
    vecs[5]  = '{8'h03,        1, "03 lsb pair"};
    vecs[6]  = '{8'h81,        0, "81 no wrap"};
    vecs[7]  = '{8'hAA,        0, "aa"};
    vecs[8]  = '{8'h0F,        3, "0f"};
    vecs[9]  = '{8'h3C,        3, "3c"};
    for (int i = 10; i < NVEC; i++) begin
      vecs[i].data     = 8'($urandom);
      vecs[i].exp_hits = pairs(vecs[i].data);
      vecs[i].name     = $sformatf("rand%0d", i);
    end

    // Reset held with start asserted: nothing moves.
    bus.start   = 1'b1;
    bus.data_in = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("reset busy", int'(bus.busy), 0);
      check("reset done", int'(bus.done), 0);
      check("reset hits", int'(bus.hits), 0);
    end
    bus.start = 1'b0;
    Resetn    = 1'b1;
    @(negedge clk);
    check("idle after reset busy", int'(bus.busy), 0);

    for (int i = 0; i < NVEC; i++) run_scan(vecs[i].data, vecs[i].exp_hits, vecs[i].name);

    // start held high; data changes during SHIFT. Second accept waits for IDLE.
    exp_q.delete();
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 8'hFF;
    exp_q.push_back(7);
    exp_q.push_back(0);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 0) bus.data_in = 8'h00;
      if (k == 10) check("held start idle gap", int'(bus.busy), 0);
      if (k == 11) check("held start reaccept", int'(bus.busy), 1);
      if (bus.done) begin
        dk.push_back(k);
        if (exp_q.size() > 0) check("held start hits", int'(bus.hits), exp_q.pop_front());
        else check("held start unexpected done", 1, 0);
      end
      if (k == 20) bus.start = 1'b0;
    end
    check("held start done count", dk.size(), 2);
    if (dk.size() == 2) begin
      check("held start done1 cycle", dk[0], 9);
      check("held start done2 cycle", dk[1], 20);
    end

    // Reset mid-SHIFT aborts the scan with no result.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid-scan hits before reset", int'(bus.hits), 1);
    Resetn = 1'b0;
    #1;
    check("async reset busy", int'(bus.busy), 0);
    check("async reset hits", int'(bus.hits), 0);
    check("async reset done", int'(bus.done), 0);
    @(negedge clk);
    Resetn = 1'b1;
    done_n = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    check("aborted scan done count", done_n, 0);
    run_scan(8'h03, 1, "post-reset 03");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
